// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: one-hot row drive, 2-flop column sync, frame-based press/release debounce.
// Latency: outputs settle one cycle after the row-3 sample edge of the deciding frame (frame = 4*SCAN_DIV cycles).
// No backpressure: key_valid is a single-cycle pulse and the consumer must take it when it appears.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int            DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int            CW        = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N     = CW'(DEBOUNCE_SCANS);
  localparam logic [3:0]    NO_KEY    = 4'd15;

  // Classification of one complete scan frame.
  typedef enum logic [1:0] {
    FRM_NONE   = 2'd0,
    FRM_SINGLE = 2'd1,
    FRM_MULTI  = 2'd2
  } frm_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Physical keypad position to key code; row 3 carries '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [1:0] ri, input logic [1:0] ci);
    logic [3:0] code;
    if (ri == 2'd3) begin
      case (ci)
        2'd0:    code = 4'd10;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = ({2'b00, ri} * 4'd3) + {2'b00, ci} + 4'd1;
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------------
  logic [2:0] r_col_s1;
  logic [2:0] r_col_s2;

  // Two-flop synchronizer on the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_s1 <= 3'b000;
      r_col_s2 <= 3'b000;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Row dwell counter and row rotation
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row;
  logic          w_sample;
  logic          w_frame_end;

  // The last dwell cycle of a row is the one whose closing edge captures that row.
  assign w_sample    = (r_dwell == DWELL_MAX);
  assign w_frame_end = w_sample && (r_row_idx == 2'd3);

  // Dwell counter wraps at SCAN_DIV-1; the row advances on the same edge the sample is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell   <= '0;
      r_row_idx <= 2'd0;
      r_row     <= 4'b0001;
    end else if (w_sample) begin
      r_dwell   <= '0;
      r_row_idx <= r_row_idx + 2'd1;
      r_row     <= {r_row[2:0], r_row[3]};
    end else begin
      r_dwell   <= r_dwell + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame accumulation
  // ---------------------------------------------------------------------------
  logic [1:0] r_acc_cnt;   // keys seen so far this frame, saturating at 2
  logic [3:0] r_acc_code;  // code of the most recent lone key seen this frame
  logic [1:0] w_pc;
  logic [3:0] w_samp_code;
  logic [1:0] w_base_cnt;
  logic [3:0] w_base_code;
  logic [2:0] w_sum;
  logic [1:0] w_acc_cnt_nxt;
  logic [3:0] w_acc_code_nxt;

  // Fold the current row's synchronized columns into the frame totals; row 0 starts afresh.
  always_comb begin
    w_pc        = {1'b0, r_col_s2[0]} + {1'b0, r_col_s2[1]} + {1'b0, r_col_s2[2]};
    w_samp_code = NO_KEY;
    case (r_col_s2)
      3'b001:  w_samp_code = key_map(r_row_idx, 2'd0);
      3'b010:  w_samp_code = key_map(r_row_idx, 2'd1);
      3'b100:  w_samp_code = key_map(r_row_idx, 2'd2);
      default: w_samp_code = NO_KEY;
    endcase
    w_base_cnt  = r_acc_cnt;
    w_base_code = r_acc_code;
    if (r_row_idx == 2'd0) begin
      w_base_cnt  = 2'd0;
      w_base_code = NO_KEY;
    end
    w_sum          = {1'b0, w_base_cnt} + {1'b0, w_pc};
    w_acc_cnt_nxt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_acc_code_nxt = (w_pc == 2'd1) ? w_samp_code : w_base_code;
  end

  logic       r_frm_vld;
  frm_t       r_frm_kind;
  logic [3:0] r_frm_code;

  // Hold accumulators between samples and register the frame verdict at the row-3 sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= NO_KEY;
      r_frm_vld  <= 1'b0;
      r_frm_kind <= FRM_NONE;
      r_frm_code <= NO_KEY;
    end else begin
      r_frm_vld <= w_frame_end;
      if (w_sample) begin
        r_acc_cnt  <= w_acc_cnt_nxt;
        r_acc_code <= w_acc_code_nxt;
      end
      if (w_frame_end) begin
        r_frm_code <= w_acc_code_nxt;
        case (w_acc_cnt_nxt)
          2'd0:    r_frm_kind <= FRM_NONE;
          2'd1:    r_frm_kind <= FRM_SINGLE;
          default: r_frm_kind <= FRM_MULTI;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic [3:0]    r_key_code;
  logic [3:0]    w_key_code_nxt;
  logic          r_key_valid;
  logic          w_key_valid_nxt;
  logic          r_key_held;
  logic          w_key_held_nxt;
  logic          r_multi_err;
  logic          w_multi_err_nxt;
  logic          w_accept;

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cand      <= NO_KEY;
      r_cnt       <= '0;
      r_key_code  <= NO_KEY;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
      r_multi_err <= w_multi_err_nxt;
    end
  end

  // Next-state logic; only advances when a frame verdict is present.
  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_cnt_inc       = r_cnt + CW'(1);
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    w_multi_err_nxt = r_multi_err;
    w_accept        = 1'b0;

    if (r_frm_vld) begin
      w_multi_err_nxt = (r_frm_kind == FRM_MULTI);
      case (r_state)
        S_IDLE: begin
          if (r_frm_kind == FRM_SINGLE) begin
            w_cand_nxt = r_frm_code;
            w_cnt_nxt  = CW'(1);
            if (DEB_N == CW'(1)) begin
              w_accept = 1'b1;
            end else begin
              w_state_nxt = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (r_frm_kind == FRM_SINGLE) begin
            if (r_frm_code == r_cand) begin
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc == DEB_N) begin
                w_accept = 1'b1;
              end
            end else begin
              // A different lone key restarts the confirmation window.
              w_cand_nxt = r_frm_code;
              w_cnt_nxt  = CW'(1);
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          // Any key activity, including a second key, just keeps the hold alive.
          if (r_frm_kind == FRM_NONE) begin
            if (DEB_N == CW'(1)) begin
              w_key_held_nxt = 1'b0;
              w_state_nxt    = S_IDLE;
            end else begin
              w_cnt_nxt   = CW'(1);
              w_state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (r_frm_kind == FRM_NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_N) begin
              w_key_held_nxt = 1'b0;
              w_state_nxt    = S_IDLE;
            end
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_accept) begin
        w_key_code_nxt  = w_cand_nxt;
        w_key_valid_nxt = 1'b1;
        w_key_held_nxt  = 1'b1;
        w_state_nxt     = S_HELD;
      end
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_err = r_multi_err;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x3 matrix keypad of the safe: drives one-hot active-high rows, samples the three column lines, and debounces across full scan frames. Emits one `key_valid` pulse with a 4-bit key code per debounced press. Sits between the keypad pins and the safe controller, replacing ad-hoc row stepping in the top level.

## Interface
- `SCAN_DIV`, default 1000000: clock cycles each row is driven. Must be at least 4.
- `DEBOUNCE_SCANS`, default 3: consecutive identical frames required to accept a press or a release. Must be at least 1.
- `clk`  in  1  system clock; all logic is on the posedge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `col`  in  3  column lines. Bit c is high when the key at (active row, column c) is pressed. Asynchronous to `clk`.
- `row`  out  4  one-hot row drive; bit r high means row r is active.
- `key_code`  out  4  code of the last accepted key; holds until the next accept.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_held`  out  1  high from accept until the debounced release.
- `multi_err`  out  1  high while the most recent frame saw two or more keys.

## Operation
- Key map, with `row[r]` and `col[c]` giving the code:
  - r0: c0 = 1, c1 = 2, c2 = 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: `*` = 10, 0 = 0, `#` = 11
  - Code 15 means no key.
- `col` passes through a 2-flop synchronizer before use.
- Dwell counter runs 0..`SCAN_DIV`-1 and wraps.
  - At count `SCAN_DIV`-1 the synchronized `col` is sampled for the current row.
  - On the next edge, `row` rotates 0001→0010→0100→1000→0001.
- Frame: the four row samples r0..r3. Per-frame accumulators are cleared at the start of each frame.
- Frame result is evaluated at the r3 sample:
  - NONE: no bits set.
  - SINGLE(k): exactly one bit set across all rows.
  - MULTI: two or more bits set.
- `multi_err` is updated at every frame end: 1 if the result is MULTI, else 0.
- Debounce FSM, advancing only at frame end. `cnt` is wide enough for `DEBOUNCE_SCANS`.
  - IDLE:
    - SINGLE(k): set cand=k, cnt=1. If `DEBOUNCE_SCANS`==1, ACCEPT; else go to CONFIRM.
    - NONE or MULTI: stay in IDLE.
  - CONFIRM:
    - SINGLE(cand): cnt++. When cnt reaches `DEBOUNCE_SCANS`, ACCEPT.
    - SINGLE(j≠cand): set cand=j, cnt=1, stay in CONFIRM.
    - NONE or MULTI: go to IDLE.
  - ACCEPT (an action, not a state): `key_code`=cand, `key_valid` pulse, `key_held`=1, go to HELD.
  - HELD:
    - NONE: cnt=1 and go to RELEASE, or go directly to IDLE if `DEBOUNCE_SCANS`==1.
    - SINGLE or MULTI of any key: stay in HELD. No new event is produced.
  - RELEASE:
    - NONE: cnt++. When cnt reaches `DEBOUNCE_SCANS`, `key_held`=0 and go to IDLE.
    - Any key seen: go back to HELD.
- Rollover is not supported: a second key pressed while one is held produces no event.

## Timing
- Reset values:
  - `row`=0001, `key_code`=15, `key_valid`=0, `key_held`=0, `multi_err`=0.
  - Dwell counter 0, FSM in IDLE, synchronizer and accumulators cleared.
- `rst_n` low at any point, including mid-frame or in HELD, forces the reset values on that edge. Scanning restarts at row 0 on the first edge with `rst_n` high.
- Frame period is 4·`SCAN_DIV` cycles.
- Latency:
  - `key_valid`, `key_code`, `key_held` and `multi_err` change one cycle after the r3 sample edge of the deciding frame.
  - For a press stable from the start of a frame, `key_valid` rises after `DEBOUNCE_SCANS` full frames plus 1 cycle.
  - A `col` change needs ≥3 cycles before a row's sample edge to be captured (2-flop sync plus sample).
- `key_valid` is never high on two consecutive cycles. Accepts are at least `DEBOUNCE_SCANS` frames apart.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=2.
- **Reset and scan:** hold `rst_n` low 3 cycles, then release with `col`=0. Required: outputs at reset values; `row` 0001 for 4 cycles, then 0010, 0100, 1000, 0001; `key_valid` stays 0 for 10 frames.
- **Single press:** drive `col[1]` high only while `row`=0010 (key 5), for 6 frames. Required: exactly one `key_valid` pulse with `key_code`=5, 1 cycle after the 2nd frame end; `key_held`=1 until 2 NONE frames after release, then 0.
- **Bounce:** key 5 for 1 frame, then NONE. Required: no `key_valid`; `key_code` remains 15.
- **Special keys:** press `*`, `0`, `#` (row 3, col 0/1/2) in turn, each separated by a full release. Required: three pulses with codes 10, 0, 11.
- **Multi-key:** press 1 (r0 c0) and 9 (r2 c2) together for 4 frames. Required: `multi_err`=1 from the first frame end, no `key_valid`; `multi_err`=0 one frame end after release.
- **Reset mid-hold:** while key 7 is held (`key_held`=1), pulse `rst_n` low 1 cycle with key 7 still pressed. Required: reset values on that edge, then a new `key_valid` with `key_code`=7 after 2 frames.
